// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block width, round counts per key size
// and the round-sequencer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEYWAIT = 2'd1,
        ST_ROUND   = 2'd2,
        ST_DONE    = 2'd3
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: fetches one round key per index,
// drives the external round datapath and returns the ciphertext.
// Build macro AES_ABORT_EN adds a synchronous abort input.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR   = AES128_NR,
    parameter int IDXW = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
`ifdef AES_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [AES_BLOCK_W-1:0] indata,
    input  logic                   invalid,
    output logic                   inready,
    output logic [AES_BLOCK_W-1:0] outdata,
    output logic                   outvalid,
    input  logic                   outready,
    output logic                   keyreq,
    output logic [IDXW-1:0]        keyidx,
    input  logic                   keyack,
    input  logic [AES_BLOCK_W-1:0] roundkey,
    output logic [AES_BLOCK_W-1:0] dpstate,
    output logic [AES_BLOCK_W-1:0] dpkey,
    output logic                   dpfinal,
    input  logic [AES_BLOCK_W-1:0] dpresult,
    output logic                   busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);
    localparam logic [IDXW-1:0] IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

    aes_state_e             state_q, state_d;
    logic [AES_BLOCK_W-1:0] statereg_q, statereg_d;
    logic [AES_BLOCK_W-1:0] keyreg_q, keyreg_d;
    logic [IDXW-1:0]        roundidx_q, roundidx_d;
    logic                   abort_s;
    logic                   is_last_s;
    logic                   is_first_s;

`ifdef AES_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign is_last_s  = (roundidx_q == LAST_IDX);
    assign is_first_s = (roundidx_q == {IDXW{1'b0}});

    // State and working registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            statereg_q <= '0;
            keyreg_q   <= '0;
            roundidx_q <= '0;
        end else begin
            state_q    <= state_d;
            statereg_q <= statereg_d;
            keyreg_q   <= keyreg_d;
            roundidx_q <= roundidx_d;
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (invalid) state_d = ST_KEYWAIT;
                    else         state_d = ST_IDLE;
                end
                ST_KEYWAIT: begin
                    if (keyack) state_d = ST_ROUND;
                    else        state_d = ST_KEYWAIT;
                end
                ST_ROUND: begin
                    if (is_last_s) state_d = ST_DONE;
                    else           state_d = ST_KEYWAIT;
                end
                ST_DONE: begin
                    if (outready) state_d = ST_IDLE;
                    else          state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Working-register updates; index 0 is the internal key whitening step.
    always_comb begin
        statereg_d = statereg_q;
        keyreg_d   = keyreg_q;
        roundidx_d = roundidx_q;
        if (abort_s) begin
            statereg_d = '0;
            roundidx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (invalid) begin
                        statereg_d = indata;
                        roundidx_d = '0;
                    end else begin
                        statereg_d = statereg_q;
                    end
                end
                ST_KEYWAIT: begin
                    if (keyack) keyreg_d = roundkey;
                    else        keyreg_d = keyreg_q;
                end
                ST_ROUND: begin
                    if (is_first_s) statereg_d = statereg_q ^ keyreg_q;
                    else            statereg_d = dpresult;
                    if (is_last_s)  roundidx_d = roundidx_q;
                    else            roundidx_d = roundidx_q + IDX_ONE;
                end
                ST_DONE: begin
                    statereg_d = statereg_q;
                end
                default: begin
                    statereg_d = '0;
                    roundidx_d = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        inready  = (state_q == ST_IDLE);
        keyreq   = (state_q == ST_KEYWAIT);
        outvalid = (state_q == ST_DONE);
        busy     = (state_q != ST_IDLE);
        dpfinal  = (state_q == ST_ROUND) && is_last_s;
        keyidx   = roundidx_q;
        outdata  = statereg_q;
        dpstate  = statereg_q;
        dpkey    = keyreg_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with behavioural AES-128 key schedule
// and round datapath models; checks against FIPS-197 ciphertexts.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR   = AES128_NR;
    localparam int IDXW = 4;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic            clk = 1'b0;
    logic            resetn;
    logic [127:0]    indata;
    logic            invalid;
    logic            inready;
    logic [127:0]    outdata;
    logic            outvalid;
    logic            outready;
    logic            keyreq;
    logic [IDXW-1:0] keyidx;
    logic            keyack;
    logic [127:0]    roundkey;
    logic [127:0]    dpstate;
    logic [127:0]    dpkey;
    logic            dpfinal;
    logic [127:0]    dpresult;
    logic            busy;
`ifdef AES_ABORT_EN
    logic            abort;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    logic key_sel;
    int   stall_idx;
    int   stall_len;
    int   stall_cnt = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn),
`ifdef AES_ABORT_EN
        .abort(abort),
`endif
        .indata(indata), .invalid(invalid), .inready(inready),
        .outdata(outdata), .outvalid(outvalid), .outready(outready),
        .keyreq(keyreq), .keyidx(keyidx), .keyack(keyack), .roundkey(roundkey),
        .dpstate(dpstate), .dpkey(dpkey), .dpfinal(dpfinal), .dpresult(dpresult),
        .busy(busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] key,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[rr+4*c] = b[rr + 4*((c+rr)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ key;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] key, input logic [IDXW-1:0] idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        int          k;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        k = int'(idx);
        if (k > 10) k = 10;
        return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    assign roundkey = key_exp(key_sel ? K2 : K1, keyidx);
    assign dpresult = aes_round(dpstate, dpkey, dpfinal);
    assign keyack   = keyreq && !((int'(keyidx) == stall_idx) && (stall_cnt < stall_len));

    // Counts cycles spent requesting the stalled index.
    always @(posedge clk) begin
        if (keyreq && int'(keyidx) == stall_idx) stall_cnt <= stall_cnt + 1;
        else                                     stall_cnt <= 0;
    end

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input string tag, input logic [127:0] pt);
        chk1({tag, " inready"}, inready, 1'b1);
        indata  = pt;
        invalid = 1'b1;
        @(negedge clk);
        invalid = 1'b0;
        chk1({tag, " busy"}, busy, 1'b1);
    endtask

    // Called on the first falling edge after the accept edge.
    task automatic wait_out(input string tag, input logic [127:0] ct, input int lat,
                            input int kreq_exp, input int kstall_exp);
        int n = 0;
        int kreq = 0;
        int kstall = 0;
        int fin = 0;
        int unstable = 0;
        logic prev_req = 1'b0;
        logic prev_ack = 1'b0;
        logic [IDXW-1:0] prev_idx = '0;
        while (outvalid !== 1'b1 && n < 200) begin
            if (keyreq === 1'b1) kreq++;
            if (keyreq === 1'b1 && int'(keyidx) == stall_idx) kstall++;
            if (dpfinal === 1'b1) fin++;
            if (prev_req && !prev_ack && (keyreq !== 1'b1 || keyidx !== prev_idx)) unstable++;
            prev_req = (keyreq === 1'b1);
            prev_ack = (keyack === 1'b1);
            prev_idx = keyidx;
            @(negedge clk);
            n++;
        end
        chkn({tag, " latency"}, n, lat);
        chkn({tag, " keyreq cycles"}, kreq, kreq_exp);
        chkn({tag, " stall idx cycles"}, kstall, kstall_exp);
        chkn({tag, " key hold"}, unstable, 0);
        chkn({tag, " dpfinal cycles"}, fin, 1);
        chkw({tag, " outdata"}, outdata, ct);
        chk1({tag, " inready in done"}, inready, 1'b0);
    endtask

    task automatic handshake(input string tag);
        outready = 1'b1;
        @(negedge clk);
        outready = 1'b0;
        chk1({tag, " idle inready"}, inready, 1'b1);
        chk1({tag, " idle outvalid"}, outvalid, 1'b0);
        chk1({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        resetn = 1'b1; indata = '0; invalid = 1'b0; outready = 1'b0;
        key_sel = 1'b0; stall_idx = 5; stall_len = 0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        #2 resetn = 1'b0;
        @(negedge clk);
        chk1("rst inready", inready, 1'b1);
        chk1("rst outvalid", outvalid, 1'b0);
        chk1("rst keyreq", keyreq, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chkw("rst outdata", outdata, 128'h0);
        chkw("rst dpstate", dpstate, 128'h0);
        chkw("rst dpkey", dpkey, 128'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        start("fips", P1);
        wait_out("fips", C1, 22, 11, 1);
        handshake("fips");

        stall_len = 3;
        start("stall", P1);
        wait_out("stall", C1, 25, 14, 4);
        stall_len = 0;
        handshake("stall");

        start("bp", P1);
        wait_out("bp", C1, 22, 11, 1);
        indata  = P2;
        invalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("bp outvalid", outvalid, 1'b1);
            chkw("bp outdata", outdata, C1);
            chk1("bp inready", inready, 1'b0);
        end
        invalid = 1'b0;
        handshake("bp");
        chkw("bp state kept", dpstate, C1);

        indata  = P1;
        invalid = 1'b1;
        @(negedge clk);
        wait_out("b2b first", C1, 22, 11, 1);
        outready = 1'b1;
        key_sel  = 1'b1;
        indata   = P2;
        @(negedge clk);
        outready = 1'b0;
        chk1("b2b inready", inready, 1'b1);
        chk1("b2b outvalid low", outvalid, 1'b0);
        @(negedge clk);
        invalid = 1'b0;
        chk1("b2b second accepted", keyreq, 1'b1);
        chkn("b2b second idx", int'(keyidx), 0);
        wait_out("b2b second", C2, 22, 11, 1);
        handshake("b2b");
        key_sel = 1'b0;

        start("rst mid", P1);
        n = 0;
        while (!(busy === 1'b1 && keyreq === 1'b0 && int'(keyidx) == 4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("rst mid reached round 4", (n < 100), 1'b1);
        resetn = 1'b0;
        #1;
        chk1("rst mid outvalid", outvalid, 1'b0);
        chk1("rst mid keyreq", keyreq, 1'b0);
        chk1("rst mid busy", busy, 1'b0);
        chk1("rst mid inready", inready, 1'b1);
        chkw("rst mid dpstate", dpstate, 128'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        start("after rst", P1);
        wait_out("after rst", C1, 22, 11, 1);
        handshake("after rst");

`ifdef AES_ABORT_EN
        start("abort", P1);
        n = 0;
        while (!(keyreq === 1'b1 && int'(keyidx) == 7) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("abort reached idx 7", (n < 100), 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk1("abort keyreq", keyreq, 1'b0);
        chk1("abort busy", busy, 1'b0);
        chk1("abort inready", inready, 1'b1);
        chkw("abort state cleared", dpstate, 128'h0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (outvalid === 1'b1) n++;
            @(negedge clk);
        end
        chkn("abort no outvalid", n, 0);
        start("after abort", P1);
        wait_out("after abort", C1, 22, 11, 1);
        handshake("after abort");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption round sequencer. It accepts a 128-bit block through a valid/ready handshake and holds the working state register. For each round it requests the round key from the key-schedule block, then drives an external combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and captures the result. It returns the ciphertext through a valid/ready handshake. It sits between the bus-facing wrapper and the round datapath and key schedule.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256).
IDXW, 4, width of the round-key index; must hold NR.

Ports:
clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  asynchronous active-low reset.
indata  input  128  plaintext block.
invalid  input  1  plaintext valid.
inready  output  1  controller can accept a block.
outdata  output  128  ciphertext block.
outvalid  output  1  ciphertext valid.
outready  input  1  consumer accepts the ciphertext.
keyreq  output  1  round-key request.
keyidx  output  IDXW  requested round-key index, 0..NR.
keyack  input  1  roundkey is valid for keyidx.
roundkey  input  128  round key from the key schedule.
dpstate  output  128  current state, driven to the datapath.
dpkey  output  128  latched round key, driven to the datapath.
dpfinal  output  1  final round; the datapath skips MixColumns.
dpresult  input  128  combinational datapath result.
busy  output  1  high in any state except IDLE.

Behaviour:
- States: IDLE, KEYWAIT, ROUND, DONE.
- Registers: statereg[127:0], keyreg[127:0], roundidx[IDXW-1:0].
- Reset (asynchronous, resetn=0):
  - State goes to IDLE.
  - statereg, keyreg and roundidx are cleared to 0.
  - Outputs during reset: keyreq=0, outvalid=0, busy=0, inready=1, outdata=0, dpstate=0, dpkey=0.
  - Reset mid-operation discards the block in flight; no partial ciphertext is presented.
- IDLE:
  - inready=1.
  - When invalid&&inready: statereg<=indata, roundidx<=0, go to KEYWAIT.
- KEYWAIT:
  - keyreq=1 and keyidx=roundidx, both held stable until keyack.
  - When keyack: keyreg<=roundkey, go to ROUND.
  - keyack in any other state is ignored.
- ROUND (exactly 1 cycle):
  - If roundidx==0: statereg<=statereg^keyreg (initial AddRoundKey, done internally; dpresult is ignored).
  - Otherwise: statereg<=dpresult.
  - dpfinal=1 only when in ROUND and roundidx==NR.
  - If roundidx==NR, go to DONE; otherwise roundidx<=roundidx+1 and go to KEYWAIT.
- DONE:
  - outvalid=1; outdata=statereg, held stable while outvalid&&!outready.
  - When outready: go to IDLE.
  - inready=0, so there is no overlap. A new block can be accepted at the earliest on the cycle after the output handshake.
- Fixed outputs: dpstate=statereg and dpkey=keyreg at all times. outdata=statereg (qualified by outvalid).
- Latency with keyack returned in the same cycle as keyreq:
  - 2 cycles per key index, NR+1 indices.
  - outvalid rises 2*(NR+1) cycles after the accept edge: 22 cycles for NR=10.
  - Each cycle keyack is held off adds 1 cycle.
- roundidx never exceeds NR; there is no wrap-around.

Optional Feature:
AES_ABORT_EN
- Defined:
  - Adds input port abort (1 bit, synchronous).
  - abort=1 in any state: next state is IDLE; statereg and roundidx are cleared; keyreq and outvalid drop on the next cycle.
  - abort has priority over every other event, including invalid in IDLE and outready in DONE.
- Undefined: the port does not exist and the behaviour is as above.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128.
  - Round-count constants AES128_NR=10, AES192_NR=12, AES256_NR=14.
  - The controller state enum type.
- No sub-module: the FSM, counter and registers stay in one module.
- The round datapath and key schedule are external. The bench provides behavioural models of both.

Test Plan:
- FIPS-197 vector, NR=10, keyack same-cycle.
  - Stimulus: indata=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: outdata=69c4e0d86a7b0430d8cdb78070b4c55a, outvalid rising exactly 22 cycles after accept.
- Key stall.
  - Stimulus: keyack delayed 3 cycles for keyidx=5 only.
  - Required: keyreq and keyidx=5 held stable throughout; same ciphertext; outvalid at cycle 25.
- Output backpressure.
  - Stimulus: outready=0 for 10 cycles in DONE.
  - Required: outvalid=1 and outdata stable; inready=0; invalid ignored.
  - Then outready=1 for 1 cycle: IDLE next cycle and inready=1.
- Back-to-back blocks.
  - Stimulus: invalid held high with two blocks.
  - Required: the second block is accepted 1 cycle after the first output handshake; both ciphertexts correct.
- Reset mid-block.
  - Stimulus: resetn=0 while in ROUND with roundidx=4.
  - Required: immediately outvalid=0, keyreq=0, busy=0, inready=1; the next block encrypts correctly.
- AES_ABORT_EN build.
  - Stimulus: abort pulsed in KEYWAIT at keyidx=7.
  - Required: IDLE next cycle, keyreq=0, no outvalid for that block.
